// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bundle.
// Hazard controls, ID-side fields and EX-side fields.
interface id_ex_pipe_reg_if #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 18
);
    logic          stall;
    logic          flush;

    logic          valid_id;
    logic [CW-1:0] ctrl_id;
    logic [DW-1:0] pc4_id;
    logic [DW-1:0] rs_data_id;
    logic [DW-1:0] rt_data_id;
    logic [DW-1:0] imm_id;
    logic [RW-1:0] rs_id;
    logic [RW-1:0] rt_id;
    logic [RW-1:0] rd_id;
    logic [4:0]    shamt_id;
    logic [5:0]    funct_id;

    logic          valid_ex;
    logic [CW-1:0] ctrl_ex;
    logic [DW-1:0] pc4_ex;
    logic [DW-1:0] rs_data_ex;
    logic [DW-1:0] rt_data_ex;
    logic [DW-1:0] imm_ex;
    logic [RW-1:0] rs_ex;
    logic [RW-1:0] rt_ex;
    logic [RW-1:0] rd_ex;
    logic [4:0]    shamt_ex;
    logic [5:0]    funct_ex;

    modport master (
        output stall, flush,
        output valid_id, ctrl_id, pc4_id,
        output rs_data_id, rt_data_id, imm_id,
        output rs_id, rt_id, rd_id,
        output shamt_id, funct_id,
        input  valid_ex, ctrl_ex, pc4_ex,
        input  rs_data_ex, rt_data_ex, imm_ex,
        input  rs_ex, rt_ex, rd_ex,
        input  shamt_ex, funct_ex
    );

    modport slave (
        input  stall, flush,
        input  valid_id, ctrl_id, pc4_id,
        input  rs_data_id, rt_data_id, imm_id,
        input  rs_id, rt_id, rd_id,
        input  shamt_id, funct_id,
        output valid_ex, ctrl_ex, pc4_ex,
        output rs_data_ex, rt_data_ex, imm_ex,
        output rs_ex, rt_ex, rd_ex,
        output shamt_ex, funct_ex
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold and flush bubble.
// Invalid slots always carry the NOP control bundle.
module id_ex_pipe_reg #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 18
) (
    input logic            clk,
    input logic            rst,
    id_ex_pipe_reg_if.slave bus
);
    localparam logic [CW-1:0] BUBBLE = CW'(18'h00002);

    logic          r_valid;
    logic [CW-1:0] r_ctrl;
    logic [DW-1:0] r_pc4;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [DW-1:0] r_imm;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic [RW-1:0] r_rd;
    logic [4:0]    r_shamt;
    logic [5:0]    r_funct;

    logic          w_load;
    logic [CW-1:0] w_ctrl_in;

    assign w_load    = !bus.stall;
    assign w_ctrl_in = (bus.valid_id == 1'b1) ? bus.ctrl_id : BUBBLE;

    // Control and valid: reset/flush empty the slot, stall holds, else load.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= BUBBLE;
        end else if (w_load) begin
            r_valid <= (bus.valid_id == 1'b1);
            r_ctrl  <= w_ctrl_in;
        end
    end

    // Data and specifiers follow the same priority, cleared to zero.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_pc4     <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_shamt   <= '0;
            r_funct   <= '0;
        end else if (w_load) begin
            r_pc4     <= bus.pc4_id;
            r_rs_data <= bus.rs_data_id;
            r_rt_data <= bus.rt_data_id;
            r_imm     <= bus.imm_id;
            r_rs      <= bus.rs_id;
            r_rt      <= bus.rt_id;
            r_rd      <= bus.rd_id;
            r_shamt   <= bus.shamt_id;
            r_funct   <= bus.funct_id;
        end
    end

    assign bus.valid_ex   = r_valid;
    assign bus.ctrl_ex    = r_ctrl;
    assign bus.pc4_ex     = r_pc4;
    assign bus.rs_data_ex = r_rs_data;
    assign bus.rt_data_ex = r_rt_data;
    assign bus.imm_ex     = r_imm;
    assign bus.rs_ex      = r_rs;
    assign bus.rt_ex      = r_rt;
    assign bus.rd_ex      = r_rd;
    assign bus.shamt_ex   = r_shamt;
    assign bus.funct_ex   = r_funct;
endmodule
